// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// buffers returned {pc, instr} pairs for decode; redirect flushes and drops in-flight data.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready,
    output logic [31:0] fetch_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   trk_q     [DEPTH];
    logic [PW-1:0] q_head_q, q_tail_q;
    logic [PW-1:0] trk_head_q, trk_tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW:0]   used;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;

    // Credits count both buffered and in-flight entries, so every response has a slot.
    assign used           = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req_valid = !rst && !redirect_valid && (used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_pc       = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop      = id_valid && id_ready && !redirect_valid;

    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? q_pc_q[q_head_q]    : '0;
    assign id_instr = id_valid ? q_instr_q[q_head_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (imem_rsp_valid) begin
            out_d = out_d - CW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (req_fire) begin
            out_d      = out_d + CW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            count_d    = '0;
            // Everything still outstanding after this cycle's retirement is stale.
            drop_d     = out_d;
        end else begin
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            trk_head_q <= '0;
            trk_tail_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            if (redirect_valid) begin
                q_head_q <= '0;
                q_tail_q <= '0;
            end else begin
                if (rsp_keep) begin
                    q_tail_q <= q_tail_q + PW'(1);
                end
                if (pop) begin
                    q_head_q <= q_head_q + PW'(1);
                end
            end
            if (req_fire) begin
                trk_tail_q <= trk_tail_q + PW'(1);
            end
            if (imem_rsp_valid) begin
                trk_head_q <= trk_head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            q_pc_q[q_tail_q]    <= trk_q[trk_head_q];
            q_instr_q[q_tail_q] <= imem_rsp_data;
        end
        if (req_fire) begin
            trk_q[trk_tail_q] <= fetch_pc_q;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned instructions with their PCs in a small queue and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect by flushing the queue and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, queue entries; must be a power of 2 and at least 2. Also bounds in-flight plus buffered instructions.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address; always equals fetch_pc.
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  instruction word returned. In order, one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- id_valid  output  1  queue head valid for decode.
- id_pc  output  32  PC of the head instruction.
- id_instr  output  32  head instruction word.
- id_ready  input  1  decode consumes the head.
- fetch_pc  output  32  next address to request.

Behaviour:
- Reset, sampled on clk while rst=1:
  - fetch_pc=RESET_PC; queue empty (count=0).
  - outstanding=0; drop_cnt=0.
  - Outputs: id_valid=0, imem_req_valid=0, id_pc=0, id_instr=0.
  - First request (addr RESET_PC) may be accepted in the first cycle with rst=0.
- Request rule:
  - imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH).
  - count and outstanding are the registered values; a pop this cycle does not free a credit until next cycle.
- Request accept (imem_req_valid && imem_req_ready):
  - fetch_pc += 4, wrapping mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - outstanding += 1.
  - Request address is pushed into an internal PC-tracking FIFO of depth DEPTH.
- imem_req_valid=1 with imem_req_ready=0: address held stable; no state change.
- Response with drop_cnt=0 and no redirect: pop the tracking-FIFO address, enqueue {addr, data} into the queue, outstanding -= 1.
- Response with drop_cnt>0: discard data, pop the tracking FIFO, drop_cnt -= 1, outstanding -= 1.
- Decode handshake:
  - id_valid = (count != 0); id_pc and id_instr are the queue head.
  - id_valid && id_ready pops the head.
  - Head is stable while id_valid=1 and id_ready=0.
- Enqueue and pop in the same cycle: count unchanged; order preserved; data written is not visible at the head until the entries ahead of it pop.
- Latency: response accepted at edge N appears on id_* at cycle N+1 if the queue was empty (registered queue, no combinational rsp->id path).
- Redirect (redirect_valid=1, highest priority after rst):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Queue cleared (count=0, id_valid=0 next cycle).
  - No request issued in the redirect cycle.
  - drop_cnt <= outstanding after this cycle's response retirement. A response arriving in the redirect cycle is discarded and consumed.
  - A pop in the redirect cycle is ignored by the block; decode owns its own flush.
- Back-to-back redirects: the last one wins; drop_cnt recomputed each time, so all earlier in-flight responses are still discarded.
- Invariant: count + outstanding <= DEPTH; drop_cnt <= outstanding.
- Reset mid-operation: all state returns to reset values next edge. Memory must not return responses for requests issued before reset; this is a system requirement.

Test Plan:
- Reset, then imem_req_ready=1 and 1-cycle response latency, id_ready=1:
  - Requests at 0x0, 0x4, 0x8.
  - id_pc sequence 0x0, 0x4, 0x8 with matching instr.
  - id_valid first high 2 cycles after the first accept.
- Backpressure, id_ready=0, DEPTH=2:
  - Exactly 2 requests accepted, then imem_req_valid=0.
  - id_pc=0x0 held stable.
  - Raising id_ready resumes requests one cycle after the first pop.
- imem_req_ready=0 for 3 cycles:
  - imem_req_valid=1 with imem_req_addr held at 0x0.
  - fetch_pc unchanged until accepted.
- Redirect to 0x0000_0102 with 2 requests in flight:
  - Both responses are discarded.
  - Next request addr 0x0000_0100.
  - First id_pc after the flush is 0x100.
- Wrap: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst mid-stream with the queue full -> next cycle id_valid=0, fetch_pc=RESET_PC, and the first request after release is RESET_PC.
